// File: rtl/register_pipeline.sv
// register_pipeline: elastic chain of STAGES register slices with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
module register_pipeline #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);
    localparam int OW = $clog2(STAGES+1);

    logic [STAGES-1:0] valid;
    logic [WIDTH-1:0]  data  [STAGES];
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_d [STAGES];

    // A stage can take new data unless it and every stage ahead of it are full
    // while the consumer stalls; written flat to keep the chain free of loops.
    for (genvar k = 0; k < STAGES; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~&valid[STAGES-1:k];
    end

    always_comb begin
        src_v[0] = in_valid & ~flush;
        src_d[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = valid[k-1];
            src_d[k] = data[k-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int k = 0; k < STAGES; k++) data[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid[k] <= ~flush & (rdy[k] ? src_v[k] : valid[k]);
                if (rdy[k] && src_v[k]) data[k] <= src_d[k];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) occupancy = occupancy + OW'(valid[k]);
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = valid[STAGES-1];
    assign out_data  = data[STAGES-1];
endmodule

// File: tb/tb_register_pipeline.sv
// tb_register_pipeline: directed and random checks of two register_pipeline
// configurations against a position-based queue model of in-flight words.
module tb_register_pipeline;
    typedef struct {
        logic [15:0] w;
        int          p;
    } item_t;
    typedef item_t iq_t[$];

    logic        clock = 0;
    logic        reset = 0;
    logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic [7:0]  a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_occ;
    logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic [15:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [15:0] b_out_data;
    logic [0:0]  b_occ;

    int  n_chk = 0;
    int  n_fail = 0;
    iq_t qa, qb;

    always #5 clock = ~clock;

    register_pipeline #(.WIDTH(8), .STAGES(2)) dut_a (
        .clock(clock), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    register_pipeline #(.WIDTH(16), .STAGES(1)) dut_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    // Each word moves one position forward per edge unless the word ahead of it
    // stays put; the oldest word leaves from position s-1 when the consumer is ready.
    function automatic iq_t adv(iq_t q, int s, bit ordy, bit fl);
        iq_t r;
        int  lim = s;
        if (fl) return r;
        for (int i = 0; i < q.size(); i++) begin
            item_t it = q[i];
            if (i == 0 && it.p == s - 1 && ordy) continue;
            if (it.p + 1 < lim) it.p = it.p + 1;
            lim = it.p;
            r.push_back(it);
        end
        return r;
    endfunction

    function automatic bit exp_rdy(iq_t q, int s, bit ordy, bit fl);
        iq_t m = adv(q, s, ordy, 1'b0);
        return !fl && (m.size() == 0 || m[m.size()-1].p > 0);
    endfunction

    function automatic bit head_valid(iq_t q, int s);
        return q.size() > 0 && q[0].p == s - 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit acc_a, acc_b;
        #1;
        check("a_in_ready", 32'(a_in_ready), 32'(exp_rdy(qa, 2, a_out_ready, a_flush)));
        check("a_out_valid", 32'(a_out_valid), 32'(head_valid(qa, 2)));
        if (head_valid(qa, 2)) check("a_out_data", 32'(a_out_data), 32'(qa[0].w[7:0]));
        check("a_occupancy", 32'(a_occ), 32'(qa.size()));
        check("b_in_ready", 32'(b_in_ready), 32'(exp_rdy(qb, 1, b_out_ready, b_flush)));
        check("b_out_valid", 32'(b_out_valid), 32'(head_valid(qb, 1)));
        if (head_valid(qb, 1)) check("b_out_data", 32'(b_out_data), 32'(qb[0].w));
        check("b_occupancy", 32'(b_occ), 32'(qb.size()));
        acc_a = a_in_valid && exp_rdy(qa, 2, a_out_ready, a_flush);
        acc_b = b_in_valid && exp_rdy(qb, 1, b_out_ready, b_flush);
        @(posedge clock);
        qa = adv(qa, 2, a_out_ready, a_flush);
        if (acc_a) qa.push_back('{w: {8'h00, a_in_data}, p: 0});
        qb = adv(qb, 1, b_out_ready, b_flush);
        if (acc_b) qb.push_back('{w: b_in_data, p: 0});
        #1;
    endtask

    task automatic reset_checks(string tag);
        check({tag, "_a_out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_a_out_data"}, 32'(a_out_data), 32'd0);
        check({tag, "_a_occupancy"}, 32'(a_occ), 32'd0);
        check({tag, "_a_in_ready"}, 32'(a_in_ready), 32'd1);
        check({tag, "_b_out_valid"}, 32'(b_out_valid), 32'd0);
        check({tag, "_b_out_data"}, 32'(b_out_data), 32'd0);
        check({tag, "_b_in_ready"}, 32'(b_in_ready), 32'd1);
    endtask

    task automatic push_a(logic [7:0] d, logic ordy);
        a_in_valid = 1; a_in_data = d; a_out_ready = ordy;
        cyc();
    endtask

    initial begin
        logic [15:0] bw [2];
        int          bi;
        #3 reset_checks("rst");
        #9 reset = 1;
        repeat (2) cyc();
        reset_checks("post_rst");

        // streaming 01..06 with consumer always ready
        for (int i = 1; i <= 6; i++) push_a(8'(i), 1'b1);
        a_in_valid = 0;
        repeat (3) cyc();

        // backpressure: A3 waits until the consumer resumes
        push_a(8'hA1, 1'b0);
        push_a(8'hA2, 1'b0);
        push_a(8'hA3, 1'b0);
        check("bp_occupancy", 32'(a_occ), 32'd2);
        push_a(8'hA3, 1'b1);
        a_in_valid = 0;
        repeat (4) cyc();

        // bubble collapse with a stalled output, then push-through
        push_a(8'h55, 1'b0);
        a_in_valid = 0;
        cyc();
        push_a(8'h66, 1'b0);
        check("bc_occupancy", 32'(a_occ), 32'd2);
        push_a(8'h77, 1'b1);
        check("pt_occupancy", 32'(a_occ), 32'd2);
        a_in_valid = 0;
        repeat (4) cyc();

        // flush with a competing input
        push_a(8'h11, 1'b0);
        push_a(8'h22, 1'b0);
        a_flush = 1;
        push_a(8'h33, 1'b0);
        a_flush = 0; a_in_valid = 0;
        check("flush_occupancy", 32'(a_occ), 32'd0);
        a_out_ready = 1;
        repeat (3) cyc();

        // refill, then reset pulsed between edges
        push_a(8'h44, 1'b0);
        push_a(8'h45, 1'b0);
        a_in_valid = 0;
        reset = 0;
        #1 reset_checks("mid_rst");
        qa.delete();
        qb.delete();
        #1 reset = 1;
        repeat (2) cyc();

        // single-slice configuration with toggling consumer
        bw[0] = 16'hBEEF; bw[1] = 16'hCAFE; bi = 0;
        for (int c = 0; c < 8; c++) begin
            b_in_valid = (bi < 2);
            b_in_data  = bw[bi < 2 ? bi : 1];
            b_out_ready = c[0];
            if (b_in_valid && exp_rdy(qb, 1, b_out_ready, 1'b0)) bi++;
            cyc();
        end
        b_in_valid = 0;

        // random traffic on both instances
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = $urandom_range(0, 3) != 0;
            a_in_data   = 8'($urandom);
            a_out_ready = $urandom_range(0, 2) != 0;
            a_flush     = $urandom_range(0, 19) == 0;
            b_in_valid  = $urandom_range(0, 1) != 0;
            b_in_data   = 16'($urandom);
            b_out_ready = $urandom_range(0, 1) != 0;
            b_flush     = $urandom_range(0, 19) == 0;
            cyc();
        end
        a_in_valid = 0; a_flush = 0; a_out_ready = 1;
        b_in_valid = 0; b_flush = 0; b_out_ready = 1;
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/register_pipeline.md
# register_pipeline

Parametrised elastic pipeline register: a chain of `STAGES` register slices, each `WIDTH` bits wide, with per-stage valid bits and a valid/ready handshake on both sides. It generalises the plain load-enabled register used across the ALU datapath. It adds variable depth, backpressure, bubble collapsing, flush and an occupancy count. It sits between ALU operand/result paths and the virtual-board I/O so that producers and consumers can stall independently without losing or duplicating data.

## Interface
- `WIDTH`, 8, data width in bits (>= 1)
- `STAGES`, 2, number of register slices (>= 1)
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous: discard all held items
- `in_valid`  in  1  producer has data on `in_data`
- `in_ready`  out  1  pipeline accepts `in_data` this cycle
- `in_data`  in  WIDTH  input word
- `out_valid`  out  1  `out_data` holds a valid item
- `out_ready`  in  1  consumer takes `out_data` this cycle
- `out_data`  out  WIDTH  output word (contents of the last stage)
- `occupancy`  out  $clog2(STAGES+1)  number of valid stages, 0..STAGES

## Operation
- State:
  - stage k (k = 0 at input, k = STAGES-1 at output) holds `data[k]` and `valid[k]`.
  - Reset value of every stage: 0.
- Ready chain (combinational):
  - `rdy[STAGES] = out_ready`.
  - `rdy[k] = ~valid[k] | rdy[k+1]`.
  - `in_ready = rdy[0] & ~flush`.
- Advance on a rising edge, for each k with `rdy[k]` = 1:
  - `valid[k] <= src_valid`.
  - `data[k] <= src_data` only if `src_valid`; otherwise data is held.
  - Source for k = 0: `in_valid & ~flush`, `in_data`.
  - Source for k > 0: stage k-1.
- Stages with `rdy[k]` = 0 hold valid and data.
- Handshake:
  - Transfer in when `in_valid & in_ready`.
  - Transfer out when `out_valid & out_ready`.
  - `in_valid` may be asserted or dropped freely; there is no requirement to hold it.
- Bubble collapsing: an empty stage always accepts, so a stalled pipeline fills completely. This holds even when `out_ready` = 0.
- Ordering: strict FIFO. Every accepted word is delivered exactly once, unless it is flushed.
- `flush` = 1:
  - All `valid[k]` clear at the next edge.
  - No input is accepted that cycle (`in_ready` = 0).
  - `out_valid` still reflects the current state, so a word taken that same cycle counts as delivered.
  - `data[k]` is not cleared.
- `out_valid = valid[STAGES-1]`, `out_data = data[STAGES-1]`.
- `occupancy` = popcount of `valid[]`, driven from registers only.
- STAGES = 1: a single full-throughput slice. `in_ready = (~out_valid | out_ready) & ~flush`.

## Timing
- Reset:
  - `reset` low clears all valid and data bits immediately, without waiting for a clock edge.
  - While reset is low, outputs read `out_valid` = 0, `out_data` = 0, `occupancy` = 0.
  - `in_ready` follows the combinational formula: 1 if `flush` = 0.
- Reset asserted mid-stream drops all in-flight words. There is no partial-state recovery.
- Latency: a word accepted at edge n is visible on `out_data`/`out_valid` after edge n+STAGES-1, when the pipeline is empty and unstalled.
- Throughput: 1 word/cycle sustained while `out_ready` = 1.
- Combinational paths:
  - `out_ready` -> `in_ready` is a combinational path of depth STAGES. This is accepted by design.
  - `in_valid`/`in_data` -> outputs: none; both are registered.
- Simultaneous events:
  - Full pipeline with `out_ready` = 1 and `in_valid` = 1: one word out and one word in at the same edge; occupancy unchanged.
  - `flush` together with an out-transfer: the output word is delivered and all stages empty.
  - `flush` together with `in_valid`: the input is not accepted.

## Test plan
- Reset, STAGES=2, WIDTH=8:
  - During reset: `out_valid`=0, `out_data`=8'h00, `occupancy`=0, `in_ready`=1.
  - Release reset with idle inputs: all of these hold.
- Streaming: push 8'h01..8'h06 back-to-back with `out_ready`=1 -> outputs 01..06 on consecutive cycles, first one after the second edge; `in_ready` constant 1.
- Backpressure:
  - Push 8'hA1, A2, A3 with `out_ready`=0 -> A1 and A2 accepted, `in_ready`=0, `occupancy`=2.
  - Then raise `out_ready` -> A1, A2, A3 appear in order with no duplicates.
- Bubble collapse:
  - Start with one word 8'h55 stalled at the output and stage 0 empty.
  - Push 8'h66 -> accepted, `occupancy`=2.
  - Push-through on a full pipeline with `out_ready`=1 -> simultaneous in/out, `occupancy` stays 2.
- Flush and reset:
  - Fill with 8'h11, 8'h22; assert `flush` with `in_valid`=1, `in_data`=8'h33 -> next cycle `occupancy`=0 and 8'h33 is never output.
  - Refill, then pulse `reset` low between edges -> `out_valid` drops immediately.
- STAGES=1, WIDTH=16: stream 16'hBEEF, 16'hCAFE while toggling `out_ready` every cycle -> each word is output once, in order; `in_ready` = `~out_valid | out_ready`.
